// File: rtl/ysyx_24070014_lsu.sv
// ysyx_24070014_lsu: single-outstanding load/store unit between the core and a word-wide memory port.
// Optional feature: define YSYX_24070014_LSU_ALIGN_CHECK_EN to make misaligned half/word accesses fault.
//
// state  | meaning
// IDLE   | ready for a new request (req_ready=1)
// REQ    | presenting the access to memory, waiting for mem_ready
// WAIT   | handshake done, waiting for mem_rvalid
// RESP   | one-cycle response pulse

`ifndef ysyx_24070014_MBASE
`define ysyx_24070014_MBASE 32'h8000_0000
`endif
`ifndef ysyx_24070014_MSIZE
`define ysyx_24070014_MSIZE 32'h0800_0000
`endif

module ysyx_24070014_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_LEN   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_LEN-1:0]   req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    output logic [WORD_LEN-1:0]   resp_rdata,
    output logic                  resp_err,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [3:0]            mem_mask,
    output logic [WORD_LEN-1:0]   mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [WORD_LEN-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // One extra bit so MBASE+MSIZE cannot wrap.
    localparam logic [ADDR_WIDTH:0] P_LO = (ADDR_WIDTH+1)'(`ysyx_24070014_MBASE);
    localparam logic [ADDR_WIDTH:0] P_HI = P_LO + (ADDR_WIDTH+1)'(`ysyx_24070014_MSIZE);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wen;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic                  r_err;
    logic [3:0]            r_mask;
    logic [WORD_LEN-1:0]   r_wdata;
    logic [WORD_LEN-1:0]   r_rdata;

    logic                  w_accept;
    logic                  w_misal;
    logic                  w_in_range;
    logic                  w_fault;
    logic [ADDR_WIDTH-1:0] w_addr_al;
    logic [3:0]            w_size_mask;
    logic [3:0]            w_mask;
    logic [WORD_LEN-1:0]   w_wdata;
    logic [WORD_LEN-1:0]   w_shift;
    logic [WORD_LEN-1:0]   w_load;

    assign w_accept = req_valid && req_ready;

`ifdef YSYX_24070014_LSU_ALIGN_CHECK_EN
    assign w_misal   = ((req_size == 2'd1) && req_addr[0]) ||
                       ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    assign w_addr_al = req_addr;
`else
    assign w_misal = 1'b0;
    // Misaligned accesses silently snap down to natural alignment.
    always_comb begin
        w_addr_al = req_addr;
        if (req_size == 2'd1) w_addr_al[0] = 1'b0;
        if (req_size == 2'd2) w_addr_al[1:0] = 2'b00;
    end
`endif

    assign w_in_range = ({1'b0, req_addr} >= P_LO) && ({1'b0, req_addr} < P_HI);
    assign w_fault    = (req_size == 2'd3) || !w_in_range || w_misal;

    always_comb begin
        case (req_size)
            2'd0:    w_size_mask = 4'b0001;
            2'd1:    w_size_mask = 4'b0011;
            2'd2:    w_size_mask = 4'b1111;
            default: w_size_mask = 4'b0000;
        endcase
        w_mask = w_size_mask << w_addr_al[1:0];
    end

    assign w_wdata = req_wdata << {w_addr_al[1:0], 3'b000};

    always_comb begin
        w_shift = mem_rdata >> {r_addr[1:0], 3'b000};
        w_load  = w_shift;
        case (r_size)
            2'd0: w_load = r_unsigned ? {{(WORD_LEN-8){1'b0}}, w_shift[7:0]}
                                      : {{(WORD_LEN-8){w_shift[7]}}, w_shift[7:0]};
            2'd1: w_load = r_unsigned ? {{(WORD_LEN-16){1'b0}}, w_shift[15:0]}
                                      : {{(WORD_LEN-16){w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_fault ? S_RESP : S_REQ;
            S_REQ:  if (mem_ready) w_next = S_WAIT;
            S_WAIT: if (mem_rvalid) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr     <= '0;
            r_wen      <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_mask     <= 4'b0000;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_addr     <= w_addr_al;
                r_wen      <= req_wen;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_err      <= w_fault;
                r_mask     <= w_mask;
                r_wdata    <= w_wdata;
                r_rdata    <= '0;
            end
        end else if ((r_state == S_WAIT) && mem_rvalid && !r_wen) begin
            r_rdata <= w_load;
        end
    end

    assign req_ready  = (r_state == S_IDLE) && reset;
    assign mem_valid  = (r_state == S_REQ);
    assign mem_addr   = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wen    = r_wen;
    assign mem_mask   = r_mask;
    assign mem_wdata  = r_wdata;
    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = (r_state == S_RESP) && r_err;
    assign resp_rdata = (r_state == S_RESP) ? r_rdata : '0;

endmodule

// File: tb/tb_ysyx_24070014_lsu.sv
// tb_ysyx_24070014_lsu: directed and random load/store transactions against a scripted memory,
// expected responses queued at request time and compared when resp_valid fires.
module tb_ysyx_24070014_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   hs_cnt = 0;

    ysyx_24070014_lsu #(.ADDR_WIDTH(32), .WORD_LEN(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_mask(mem_mask), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_valid && mem_ready) hs_cnt <= hs_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Independent reference for the random phase, written from the access rules.
    function automatic void model(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] size, input logic uns, input logic [31:0] mrdata,
                                  output logic fault, output logic [31:0] maddr, output logic [3:0] mask,
                                  output logic [31:0] mwdata, output logic [31:0] rdata);
        logic [1:0]  off;
        logic [31:0] sh;
        off   = addr[1:0];
        fault = (size == 2'd3) || (addr < 32'h8000_0000) || (addr >= 32'h8800_0000);
`ifdef YSYX_24070014_LSU_ALIGN_CHECK_EN
        if ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)) fault = 1'b1;
`else
        if (size == 2'd1) off[0] = 1'b0;
        if (size == 2'd2) off = 2'b00;
`endif
        maddr  = {addr[31:2], 2'b00};
        mask   = (size == 2'd0) ? (4'b0001 << off) : (size == 2'd1) ? (4'b0011 << off) : 4'b1111;
        mwdata = wdata << (8 * off);
        sh     = mrdata >> (8 * off);
        if (size == 2'd0)      rdata = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
        else if (size == 2'd1) rdata = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        else                   rdata = sh;
        if (wen) rdata = 32'h0;
    endfunction

    task automatic do_access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input logic uns, input logic [31:0] mrdata,
                             input int rdy_dly, input int rv_dly, input logic fault,
                             input logic [31:0] e_maddr, input logic [3:0] e_mask,
                             input logic [31:0] e_wdata, input logic [31:0] e_rdata, input string tag);
        exp_t e;
        exp_t got;
        int   hs0;
        e.err   = fault;
        e.rdata = (fault || wen) ? 32'h0 : e_rdata;
        sb.push_back(e);
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL %s req_ready: got %b expected 1", tag, req_ready);
        end
        hs0 = hs_cnt;
        tick;
        req_valid = 1'b0;
        if (!fault) begin
            for (int i = 0; i <= rdy_dly; i++) begin
                n_cmp++;
                if ({mem_valid, mem_wen, mem_mask, mem_addr, mem_wdata} !== {1'b1, wen, e_mask, e_maddr, e_wdata}) begin
                    n_err++;
                    $display("FAIL %s mem_req[%0d]: got v=%b wen=%b mask=%b addr=%h wdata=%h expected v=1 wen=%b mask=%b addr=%h wdata=%h",
                             tag, i, mem_valid, mem_wen, mem_mask, mem_addr, mem_wdata, wen, e_mask, e_maddr, e_wdata);
                end
                mem_rvalid = 1'b1;
                mem_rdata  = ~mrdata;
                if (i == rdy_dly) mem_ready = 1'b1;
                tick;
                mem_ready  = 1'b0;
                mem_rvalid = 1'b0;
            end
            n_cmp++;
            if (mem_valid !== 1'b0 || resp_valid !== 1'b0) begin
                n_err++; $display("FAIL %s wait_state: got mem_valid=%b resp_valid=%b expected 0 0", tag, mem_valid, resp_valid);
            end
            repeat (rv_dly) tick;
            mem_rvalid = 1'b1;
            mem_rdata  = mrdata;
            tick;
            mem_rdata  = ~mrdata;
            n_cmp++;
            if (hs_cnt !== hs0 + 1) begin
                n_err++; $display("FAIL %s handshakes: got %0d expected 1", tag, hs_cnt - hs0);
            end
        end else begin
            n_cmp++;
            if (mem_valid !== 1'b0 || hs_cnt !== hs0) begin
                n_err++; $display("FAIL %s fault_no_mem: got mem_valid=%b handshakes=%0d expected 0 0", tag, mem_valid, hs_cnt - hs0);
            end
        end
        n_cmp++;
        if (resp_valid !== 1'b1) begin
            n_err++; $display("FAIL %s resp_timing: got resp_valid=%b expected 1", tag, resp_valid);
            e = sb.pop_front();
        end else begin
            got.err = resp_err; got.rdata = resp_rdata;
            e = sb.pop_front();
            if (got !== e) begin
                n_err++; $display("FAIL %s resp: got err=%b rdata=%h expected err=%b rdata=%h", tag, got.err, got.rdata, e.err, e.rdata);
            end
        end
        tick;
        mem_rvalid = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_err++; $display("FAIL %s resp_pulse: got resp_valid=%b expected 0", tag, resp_valid);
        end
    endtask

    task automatic test_reset;
        repeat (3) tick;
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, resp_rdata, mem_valid, mem_wen, mem_mask, mem_addr, mem_wdata} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got rdy=%b rv=%b err=%b rdata=%h mv=%b wen=%b mask=%b addr=%h wdata=%h expected all 0",
                              req_ready, resp_valid, resp_err, resp_rdata, mem_valid, mem_wen, mem_mask, mem_addr, mem_wdata);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        repeat (2) begin
            tick;
            n_cmp++;
            if (resp_valid !== 1'b0) begin
                n_err++; $display("FAIL stray_rvalid_idle: got resp_valid=%b expected 0", resp_valid);
            end
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic test_store_byte;
        do_access(1'b1, 32'h8000_0003, 32'h0000_00A5, 2'd0, 1'b0, 32'hFFFF_FFFF, 0, 0, 1'b0,
                  32'h8000_0000, 4'b1000, 32'hA500_0000, 32'h0, "store_byte");
        do_access(1'b1, 32'h8000_0106, 32'h0000_BEEF, 2'd1, 1'b0, 32'h0, 1, 1, 1'b0,
                  32'h8000_0104, 4'b1100, 32'hBEEF_0000, 32'h0, "store_half");
    endtask

    task automatic test_load_ext;
        do_access(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 32'h8001_1234, 0, 0, 1'b0,
                  32'h8000_0000, 4'b1100, 32'h0, 32'hFFFF_8001, "load_half_s");
        do_access(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 32'h8001_1234, 0, 1, 1'b0,
                  32'h8000_0000, 4'b1100, 32'h0, 32'h0000_8001, "load_half_u");
        do_access(1'b0, 32'h8000_0041, 32'h0, 2'd0, 1'b0, 32'h1122_9344, 0, 0, 1'b0,
                  32'h8000_0040, 4'b0010, 32'h0, 32'hFFFF_FF93, "load_byte_s");
        do_access(1'b0, 32'h8000_0040, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, 0, 1'b0,
                  32'h8000_0040, 4'b1111, 32'h0, 32'hDEAD_BEEF, "load_word");
    endtask

    task automatic test_faults;
        do_access(1'b0, 32'h0000_1000, 32'h0, 2'd2, 1'b0, 32'h0, 0, 0, 1'b1,
                  32'h0, 4'b0, 32'h0, 32'h0, "fault_low");
        do_access(1'b0, 32'h8800_0000, 32'h0, 2'd2, 1'b0, 32'h0, 0, 0, 1'b1,
                  32'h0, 4'b0, 32'h0, 32'h0, "fault_top");
        do_access(1'b0, 32'h7FFF_FFFC, 32'h0, 2'd2, 1'b0, 32'h0, 0, 0, 1'b1,
                  32'h0, 4'b0, 32'h0, 32'h0, "fault_below");
        do_access(1'b1, 32'h8000_0000, 32'h55, 2'd3, 1'b0, 32'h0, 0, 0, 1'b1,
                  32'h0, 4'b0, 32'h0, 32'h0, "fault_size3");
        do_access(1'b0, 32'h87FF_FFFC, 32'h0, 2'd2, 1'b0, 32'h0BAD_F00D, 0, 0, 1'b0,
                  32'h87FF_FFFC, 4'b1111, 32'h0, 32'h0BAD_F00D, "last_word");
    endtask

    task automatic test_ready_stall;
        do_access(1'b1, 32'h8000_0201, 32'h0000_003C, 2'd0, 1'b0, 32'h0, 5, 2, 1'b0,
                  32'h8000_0200, 4'b0010, 32'h0000_3C00, 32'h0, "ready_stall");
    endtask

    task automatic test_align;
`ifdef YSYX_24070014_LSU_ALIGN_CHECK_EN
        do_access(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0, 32'h0, 0, 0, 1'b1,
                  32'h0, 4'b0, 32'h0, 32'h0, "align_word");
        do_access(1'b0, 32'h8000_0003, 32'h0, 2'd1, 1'b0, 32'h0, 0, 0, 1'b1,
                  32'h0, 4'b0, 32'h0, 32'h0, "align_half");
`else
        do_access(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0, 32'hCAFE_1234, 0, 0, 1'b0,
                  32'h8000_0000, 4'b1111, 32'h0, 32'hCAFE_1234, "align_word");
        do_access(1'b0, 32'h8000_0003, 32'h0, 2'd1, 1'b1, 32'hCAFE_1234, 0, 0, 1'b0,
                  32'h8000_0000, 4'b1100, 32'h0, 32'h0000_CAFE, "align_half");
`endif
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0010; req_wdata = 32'hCAFE_F00D;
        req_size = 2'd2; req_unsigned = 1'b0;
        tick;
        req_valid = 1'b0;
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, resp_rdata, mem_valid, mem_wen, mem_mask, mem_addr, mem_wdata} !== '0) begin
            n_err++; $display("FAIL reset_mid_outputs: got rdy=%b rv=%b err=%b rdata=%h mv=%b wen=%b mask=%b addr=%h wdata=%h expected all 0",
                              req_ready, resp_valid, resp_err, resp_rdata, mem_valid, mem_wen, mem_mask, mem_addr, mem_wdata);
        end
        mem_rvalid = 1'b1;
        repeat (2) begin
            tick;
            n_cmp++;
            if (resp_valid !== 1'b0) begin
                n_err++; $display("FAIL reset_mid_no_resp: got resp_valid=%b expected 0", resp_valid);
            end
        end
        mem_rvalid = 1'b0;
        reset = 1'b1;
        tick;
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_release: got req_ready=%b resp_valid=%b expected 1 0", req_ready, resp_valid);
        end
        do_access(1'b0, 32'h8000_0010, 32'h0, 2'd0, 1'b1, 32'h0000_00F0, 0, 0, 1'b0,
                  32'h8000_0010, 4'b0001, 32'h0, 32'h0000_00F0, "after_reset");
    endtask

    task automatic test_back_to_back;
        logic        wen, uns, fault;
        logic [1:0]  size;
        logic [31:0] addr, wdata, mrdata, maddr, mwdata, rdata;
        logic [3:0]  mask;
        for (int n = 0; n < 24; n++) begin
            wen    = 1'($urandom_range(0, 1));
            uns    = 1'($urandom_range(0, 1));
            size   = 2'($urandom_range(0, 2));
            wdata  = $urandom;
            mrdata = $urandom;
            case ($urandom_range(0, 7))
                0:       addr = 32'($urandom_range(0, 32'hFFFF));
                1:       addr = 32'h8800_0000 + 32'($urandom_range(0, 32'hFF));
                default: addr = 32'h8000_0000 + 32'($urandom_range(0, 32'hFFF));
            endcase
            model(wen, addr, wdata, size, uns, mrdata, fault, maddr, mask, mwdata, rdata);
            do_access(wen, addr, wdata, size, uns, mrdata, $urandom_range(0, 2), $urandom_range(0, 2),
                      fault, maddr, mask, mwdata, rdata, "rand");
        end
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_unsigned = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset;
        test_store_byte;
        test_load_ext;
        test_faults;
        test_ready_stall;
        test_align;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
